sm_hex_display: RTL and testbench
=================================

// Module: sm_hex_display
// PURPOSE
//  Output-side counterpart to the board input filters. Drives a multiplexed, common-anode
//  7-segment display with a 32-bit CPU value (regData or extOutput), one hex digit per slot.
//  Scan and refresh timing come from an internal counter on the fast board clock.
//  Loads are tear-free: a captured value goes on display only at a frame boundary.
// PARAMETERS
//  DIGITS     8   number of digits scanned, legal 1..8; data width = 4*DIGITS
//  REFRESH_W  16  slot counter width; each digit is shown for 2**REFRESH_W clk cycles
//  DEAD_W     13  anti-ghost dead time per slot = 2**DEAD_W cycles, all anodes off; DEAD_W < REFRESH_W
// PORTS
//  clk        in   1         board clock (undivided clkIn domain)
//  rst        in   1         synchronous reset, active-high
//  data       in   4*DIGITS  value to display, digit 0 = data[3:0]
//  load       in   1         capture strobe for data/dp
//  dp         in   DIGITS    decimal point per digit, 1 = lit
//  lzBlank    in   1         1 = blank leading zero digits (digit 0 is never blanked)
//  anodes     out  DIGITS    digit enables, active-low, one-hot-low or all 1
//  segments   out  7         {g,f,e,d,c,b,a}, active-low
//  dot        out  1         decimal point, active-low
//  frame      out  1         1-cycle pulse when slot DIGITS-1 wraps to slot 0
// BEHAVIOUR
//  - Reset: anodes all 1, segments 7'h7F, dot 1, frame 0; slot counter 0, digit index 0;
//    active/pending registers 0; pendValid 0. Display dark for the first slot's dead time.
//  - Slot counter: increments every clk. On reaching 2**REFRESH_W-1 it wraps to 0 and the digit
//    index advances; the index wraps DIGITS-1 -> 0, which is a frame boundary (frame=1 that cycle).
//  - load=1: pending <= {data,dp}, pendValid <= 1. A second load before the boundary overwrites.
//  - Frame boundary: if pendValid, active <= pending and pendValid <= 0.
//  - load and boundary in the same cycle: active <= the new {data,dp} directly; pendValid <= 0.
//  - Outputs are registered. They reflect the slot counter and index values from the
//    previous cycle (1-cycle latency).
//  - Dead time: while slot counter < 2**DEAD_W, anodes=all 1, segments=7'h7F, dot=1.
//  - Lit phase: anodes[idx]=0 and all other bits 1; segments=~seg(active nibble idx);
//    dot=~active_dp[idx].
//  - Blanking: if lzBlank and idx!=0 and all active nibbles >= idx are 0, then segments=7'h7F
//    and dot=~dp[idx]. The anode is still driven so a decimal point can show.
//  - Encoding: standard hex glyphs 0-9, A, b, C, d, E, F (e.g. 0 -> abcdef, 1 -> bc).
//  - Reset mid-frame: everything returns to reset values in the next cycle; pending is lost.
//  - The DIGITS=1 case must work: every slot wrap is a frame boundary.
// STRUCTURE
//  - Glyph constants (SEG_0..SEG_F, SEG_BLANK) go in the shared settings header, so other
//    display users reuse them.
//  - Sub-module sm_hex_to_seg: combinational 4-bit -> 7-bit, active-high segment decoder.
//  - Top module contains the slot counter, index, pending/active registers, LZ mask and
//    output registers.
// TESTING  (bench: DIGITS=8, REFRESH_W=4, DEAD_W=2)
//  - Reset, then run 1 frame (128 cycles) with no load -> digit 0 lit as '0' (segments=7'h40);
//    frame pulses at cycle 128.
//  - load data=32'h1234ABCD, dp=8'h01 mid-frame -> old value shown until the boundary; next frame
//    digit0='D'(7'h21) with dot=0, digit7='1'(7'h79).
//  - lzBlank=1, data=32'h0000_00F0 -> digits 2..7 segments 7'h7F; digit1='F'(7'h0E);
//    digit0='0' (7'h40).
//  - load asserted exactly in the frame-pulse cycle with 32'hFFFF_FFFF -> all digits 'F'
//    in the very next frame.
//  - Each slot: first 4 cycles all anodes=8'hFF; then exactly one anode low for 12 cycles.
//    Check anode sequence FE,FD,...,7F.
//  - Assert rst for 1 cycle mid-slot 5 -> next cycle anodes=8'hFF, index 0, pending discarded.

Source files
------------

// File: rtl/sm_hex_display_pkg.sv
// Shared display settings: active-high hex glyphs for 7-segment users, bit order {g,f,e,d,c,b,a}.
package sm_hex_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Common-anode pins are active-low, so a dark digit drives every segment high.
  localparam logic [6:0] SEG_DARK  = ~SEG_BLANK;

  localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module sm_hex_to_seg
  import sm_hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sm_hex_display.sv
// Multiplexed common-anode hex display driver with tear-free (frame-synchronous) value loads.
module sm_hex_display
  import sm_hex_display_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int REFRESH_W = 16,
  parameter int DEAD_W    = 13
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lzBlank,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments,
  output logic                  dot,
  output logic                  frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [REFRESH_W-1:0] slotCnt;
  logic [IDX_W-1:0]     digIdx;
  logic [4*DIGITS-1:0]  activeData;
  logic [4*DIGITS-1:0]  pendData;
  logic [DIGITS-1:0]    activeDp;
  logic [DIGITS-1:0]    pendDp;
  logic                 pendValid;
  logic                 slotWrap;
  logic                 boundary;
  logic                 deadTime;
  logic [3:0]           curNibble;
  logic [6:0]           glyph;
  logic [DIGITS-1:0]    lzMask;
  logic                 zeroAbove;

  assign slotWrap  = &slotCnt;
  assign boundary  = slotWrap && (digIdx == LAST_IDX);
  assign deadTime  = (slotCnt[REFRESH_W-1:DEAD_W] == '0);
  assign curNibble = activeData[4*digIdx +: 4];

  sm_hex_to_seg u_hexToSeg (
    .nibble (curNibble),
    .seg    (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slotCnt <= '0;
      digIdx  <= '0;
    end else begin
      slotCnt <= slotCnt + REFRESH_W'(1);
      if (slotWrap)
        digIdx <= (digIdx == LAST_IDX) ? '0 : digIdx + IDX_W'(1);
    end
  end

  // A load landing on the boundary bypasses pending so it is not held back a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      activeData <= '0;
      activeDp   <= '0;
      pendData   <= '0;
      pendDp     <= '0;
      pendValid  <= 1'b0;
    end else if (boundary) begin
      pendValid <= 1'b0;
      if (load) begin
        activeData <= data;
        activeDp   <= dp;
      end else if (pendValid) begin
        activeData <= pendData;
        activeDp   <= pendDp;
      end
    end else if (load) begin
      pendData  <= data;
      pendDp    <= dp;
      pendValid <= 1'b1;
    end
  end

  // lzMask[i] is set when digit i and every digit above it are zero; digit 0 is never masked.
  always_comb begin
    zeroAbove = 1'b1;
    lzMask    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeroAbove = zeroAbove & (activeData[4*i +: 4] == 4'h0);
      lzMask[i] = zeroAbove;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anodes   <= '1;
      segments <= SEG_DARK;
      dot      <= 1'b1;
      frame    <= 1'b0;
    end else begin
      frame <= boundary;
      if (deadTime) begin
        anodes   <= '1;
        segments <= SEG_DARK;
        dot      <= 1'b1;
      end else begin
        anodes   <= ~(DIGITS'(1) << digIdx);
        segments <= (lzBlank && lzMask[digIdx]) ? SEG_DARK : ~glyph;
        dot      <= ~activeDp[digIdx];
      end
    end
  end

endmodule

// File: tb/tb_sm_hex_display.sv
// Randomized bench for sm_hex_display against a time-based reference model, plus literal pins.
module tb_sm_hex_display;

  localparam int DIGITS    = 8;
  localparam int REFRESH_W = 4;
  localparam int DEAD_W    = 2;
  localparam int SLOT      = 1 << REFRESH_W;
  localparam int DEAD      = 1 << DEAD_W;
  localparam int FRAME     = SLOT * DIGITS;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         data;
  logic                load;
  logic [7:0]          dp;
  logic                lzBlank;
  logic [7:0]          anodes;
  logic [6:0]          segments;
  logic                dot;
  logic                frame;

  int vectors = 0;
  int miscompares = 0;
  int edgeCnt = 0;

  // Active-low glyphs for hex digits 0..F, written out from the segment drawings.
  logic [6:0] glyphLow [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] anodeSeq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  sm_hex_display #(.DIGITS(DIGITS), .REFRESH_W(REFRESH_W), .DEAD_W(DEAD_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .load     (load),
    .dp       (dp),
    .lzBlank  (lzBlank),
    .anodes   (anodes),
    .segments (segments),
    .dot      (dot),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: position in time since reset decides slot and digit.
  int          mT;
  logic [31:0] mActData, mPendData;
  logic [7:0]  mActDp, mPendDp;
  bit          mPendValid;
  bit          expValid = 0;
  logic [7:0]  expAnodes;
  logic [6:0]  expSegments;
  logic        expDot, expFrame;

  always @(posedge clk) begin
    int slot, idx;
    bit bnd;
    if (rst) begin
      mT = 0; mActData = 0; mActDp = 0; mPendData = 0; mPendDp = 0; mPendValid = 0;
      expAnodes = 8'hFF; expSegments = 7'h7F; expDot = 1; expFrame = 0;
      expValid = 1;
    end else if (expValid) begin
      slot = mT % SLOT;
      idx  = (mT / SLOT) % DIGITS;
      bnd  = (mT % FRAME) == FRAME - 1;
      expFrame = bnd;
      if (slot < DEAD) begin
        expAnodes = 8'hFF; expSegments = 7'h7F; expDot = 1;
      end else begin
        expAnodes = ~(8'd1 << idx);
        expDot = ~mActDp[idx];
        if (lzBlank && idx != 0 && (mActData >> (4 * idx)) == 0)
          expSegments = 7'h7F;
        else
          expSegments = glyphLow[(mActData >> (4 * idx)) & 32'hF];
      end
      if (bnd) begin
        if (load) begin mActData = data; mActDp = dp; end
        else if (mPendValid) begin mActData = mPendData; mActDp = mPendDp; end
        mPendValid = 0;
      end else if (load) begin
        mPendData = data; mPendDp = dp; mPendValid = 1;
      end
      mT++;
    end
  end

  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("modelAnodes", {24'h0, anodes}, {24'h0, expAnodes});
      checkOutput("modelSegments", {25'h0, segments}, {25'h0, expSegments});
      checkOutput("modelDot", {31'h0, dot}, {31'h0, expDot});
      checkOutput("modelFrame", {31'h0, frame}, {31'h0, expFrame});
    end
  end

  task automatic goToEdge(input int target);
    while (edgeCnt < target) begin
      @(negedge clk);
      edgeCnt++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value, input logic [7:0] dpVal);
    data = value;
    dp   = dpVal;
    load = 1'b1;
    goToEdge(edgeCnt + 1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; lzBlank = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetAnodes", {24'h0, anodes}, 32'hFF);
    checkOutput("resetSegments", {25'h0, segments}, 32'h7F);
    checkOutput("resetDot", {31'h0, dot}, 32'h1);
    checkOutput("resetFrame", {31'h0, frame}, 32'h0);
    rst = 1'b0;
    edgeCnt = 0;

    // First frame with nothing loaded: dead time then one anode per slot.
    for (int d = 0; d < DIGITS; d++) begin
      goToEdge(SLOT * d + DEAD);
      checkOutput("deadAnodes", {24'h0, anodes}, 32'hFF);
      goToEdge(SLOT * d + DEAD + 1);
      checkOutput("anodeSeq", {24'h0, anodes}, {24'h0, anodeSeq[d]});
      if (d == 0) checkOutput("idleDigit0", {25'h0, segments}, 32'h40);
    end
    goToEdge(FRAME - 1);
    checkOutput("frameEarly", {31'h0, frame}, 32'h0);
    goToEdge(FRAME);
    checkOutput("framePulse", {31'h0, frame}, 32'h1);

    // Mid-frame load stays pending until the next boundary.
    goToEdge(FRAME + 40);
    applyStimulus(32'h1234_ABCD, 8'h01);
    goToEdge(FRAME + 4 * SLOT + DEAD + 1);
    checkOutput("oldValueHeld", {25'h0, segments}, 32'h40);
    goToEdge(2 * FRAME + DEAD + 1);
    checkOutput("loadDigit0", {25'h0, segments}, 32'h21);
    checkOutput("loadDot0", {31'h0, dot}, 32'h0);
    goToEdge(2 * FRAME + 4 * SLOT + DEAD + 1);
    checkOutput("loadDigit4", {25'h0, segments}, 32'h19);
    goToEdge(2 * FRAME + 7 * SLOT + DEAD + 1);
    checkOutput("loadDigit7", {25'h0, segments}, 32'h79);
    checkOutput("loadDot7", {31'h0, dot}, 32'h1);

    // Leading-zero blanking keeps the anode but darkens the segments.
    lzBlank = 1'b1;
    goToEdge(2 * FRAME + 80);
    applyStimulus(32'h0000_00F0, 8'h00);
    goToEdge(3 * FRAME + DEAD + 1);
    checkOutput("lzDigit0", {25'h0, segments}, 32'h40);
    goToEdge(3 * FRAME + SLOT + DEAD + 1);
    checkOutput("lzDigit1", {25'h0, segments}, 32'h0E);
    for (int d = 2; d < DIGITS; d++) begin
      goToEdge(3 * FRAME + SLOT * d + DEAD + 1);
      checkOutput("lzBlanked", {25'h0, segments}, 32'h7F);
      checkOutput("lzAnode", {24'h0, anodes}, {24'h0, anodeSeq[d]});
    end

    // Load in the boundary cycle goes straight to the next frame.
    goToEdge(4 * FRAME - 1);
    applyStimulus(32'hFFFF_FFFF, 8'h00);
    checkOutput("bndFrame", {31'h0, frame}, 32'h1);
    goToEdge(4 * FRAME + DEAD + 1);
    checkOutput("bndDigit0", {25'h0, segments}, 32'h0E);
    goToEdge(4 * FRAME + 7 * SLOT + DEAD + 1);
    checkOutput("bndDigit7", {25'h0, segments}, 32'h0E);

    // Reset inside slot 5 drops the pending value.
    lzBlank = 1'b0;
    goToEdge(5 * FRAME + 10);
    applyStimulus(32'h0000_0007, 8'h00);
    goToEdge(5 * FRAME + 5 * SLOT + 8);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstAnodes", {24'h0, anodes}, 32'hFF);
    checkOutput("midRstSegments", {25'h0, segments}, 32'h7F);
    rst = 1'b0;
    edgeCnt = 0;
    goToEdge(DEAD + 1);
    checkOutput("midRstIdx0", {24'h0, anodes}, 32'hFE);
    checkOutput("midRstActive", {25'h0, segments}, 32'h40);
    goToEdge(FRAME + DEAD + 1);
    checkOutput("pendingLost", {25'h0, segments}, 32'h40);

    // Random traffic, occasional resets, checked entirely by the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      load = ($urandom_range(0, 11) == 0);
      data = $urandom;
      dp   = 8'($urandom);
      if ($urandom_range(0, 199) == 0) lzBlank = ~lzBlank;
      if ($urandom_range(0, 3) == 0) data = data & (32'hFFFF_FFFF >> (4 * $urandom_range(1, 7)));
      rst  = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
